// File: rtl/mem_access_stage.sv
// Memory-access stage: EX/MEM inputs -> data-memory valid/ready bus -> registered MEM/WB slot.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of masking low address bits.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] result_in,
  input  logic [31:0] data2_in,
  input  logic [31:0] sum_out_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  rd_in,
  input  logic        we_in,
  input  logic [1:0]  controlRF_in,
  input  logic [2:0]  Type_dm_in,
  input  logic        store_in,
  input  logic        load_in,
  output logic        stall_out,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic        bus_err_out,
  output logic        misalign_out
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_q, misalign_d;

  logic        mem_op, is_half, is_word, misalign, stall;
  logic [1:0]  lane;
  logic [31:0] shifted, load_val, wb_src, st_wdata;
  logic [3:0]  st_be;

  assign mem_op  = ex_valid & (load_in | store_in);
  assign is_half = (Type_dm_in[1:0] == 2'b01);
  assign is_word = Type_dm_in[1];
  // Byte lane actually used: half ignores addr[0], word ignores addr[1:0].
  assign lane    = is_word ? 2'b00 : (is_half ? {result_in[1], 1'b0} : result_in[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = mem_op & ((is_half & result_in[0]) | (is_word & (|result_in[1:0])));
`else
  assign misalign = 1'b0;
`endif

  assign shifted = rdata_q >> {lane, 3'b000};

  always_comb begin
    load_val = shifted;
    if (is_half)
      load_val = {{16{shifted[15] & ~Type_dm_in[2]}}, shifted[15:0]};
    else if (!is_word)
      load_val = {{24{shifted[7] & ~Type_dm_in[2]}}, shifted[7:0]};
  end

  always_comb begin
    wb_src = result_in;
    case (controlRF_in)
      2'b01:   wb_src = load_val;
      2'b10:   wb_src = sum_out_in;
      2'b11:   wb_src = imm_in;
      default: wb_src = result_in;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = data2_in;
    if (store_in) begin
      if (is_half) begin
        st_be    = result_in[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{data2_in[15:0]}};
      end else if (!is_word) begin
        st_be    = 4'b0001 << result_in[1:0];
        st_wdata = {4{data2_in[7:0]}};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    bus_err_d  = 1'b0;
    misalign_d = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !misalign) begin
          stall   = 1'b1;
          state_d = REQ;
          wait_d  = 8'd0;
          err_d   = 1'b0;
          req_d   = 1'b1;
          we_d    = store_in;
          addr_d  = {result_in[31:2], 2'b00};
          wdata_d = st_wdata;
          be_d    = st_be;
        end else begin
          wb_valid_d = ex_valid;
          wb_we_d    = ex_valid & we_in & ~misalign;
          wb_rd_d    = rd_in;
          wb_data_d  = wb_src;
          misalign_d = misalign;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dm_ready) begin
          rdata_d = dm_rdata;
          req_d   = 1'b0;
          state_d = RESP;
        end else if (wait_q == WAIT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP: begin
        // Upstream advances on this same edge, so the instruction retires exactly once.
        state_d    = IDLE;
        wb_valid_d = ex_valid;
        wb_we_d    = ex_valid & we_in & ~err_q;
        wb_rd_d    = rd_in;
        wb_data_d  = wb_src;
        bus_err_d  = err_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= 8'd0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= 32'd0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  assign stall_out    = stall;
  assign dm_req       = req_q;
  assign dm_we        = we_q;
  assign dm_addr      = addr_q;
  assign dm_wdata     = wdata_q;
  assign dm_be        = be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_we        = wb_we_q;
  assign wb_data      = wb_data_q;
  assign bus_err_out  = bus_err_q;
  assign misalign_out = misalign_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus random bench for mem_access_stage against an arithmetic reference model.
module tb_mem_access_stage;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] result_in, data2_in, sum_out_in, imm_in;
  logic [4:0]  rd_in;
  logic        we_in;
  logic [1:0]  controlRF_in;
  logic [2:0]  Type_dm_in;
  logic        store_in, load_in;
  logic        stall_out, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        bus_err_out, misalign_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .result_in(result_in), .data2_in(data2_in),
    .sum_out_in(sum_out_in), .imm_in(imm_in), .rd_in(rd_in), .we_in(we_in),
    .controlRF_in(controlRF_in), .Type_dm_in(Type_dm_in), .store_in(store_in), .load_in(load_in),
    .stall_out(stall_out), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ready(dm_ready), .dm_rdata(dm_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_data(wb_data), .bus_err_out(bus_err_out), .misalign_out(misalign_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] t);
    if (t[1]) return 4;
    if (t[0]) return 2;
    return 1;
  endfunction

  function automatic int offset_of(input logic [31:0] addr, input logic [2:0] t);
    int sz = size_of(t);
    return (int'(addr % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] t,
                                             input logic [31:0] rdata);
    int sz = size_of(t);
    logic [31:0] v    = rdata >> (8 * offset_of(addr, t));
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = v & mask;
    if (!t[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [2:0] t,
                                          input logic st);
    int sz = size_of(t);
    if (!st) return 4'hF;
    return 4'(((1 << sz) - 1) << offset_of(addr, t));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d2, input logic [2:0] t);
    logic [31:0] w;
    int sz = size_of(t);
    for (int i = 0; i < 4; i++) w[8 * i +: 8] = 8'(d2 >> (8 * (i % sz)));
    return w;
  endfunction

  // Presents one instruction, serves the bus, and checks stalls, bus fields and the WB slot.
  task automatic do_op(input string tag, input logic v, input logic [31:0] addr,
                       input logic [31:0] d2, input logic [2:0] t, input logic st,
                       input logic ld, input logic we, input logic [1:0] ctrl,
                       input logic [4:0] rd, input int delay, input logic [31:0] rdata);
    logic is_mem, mis, active, tout, done, data_known;
    int exp_stalls, exp_reqs, stalls, reqs, sz;
    logic [31:0] exp_data;
    ex_valid = v; result_in = addr; data2_in = d2; Type_dm_in = t; store_in = st;
    load_in = ld; we_in = we; controlRF_in = ctrl; rd_in = rd;
    sum_out_in = $urandom; imm_in = $urandom; dm_ready = 1'b0;
    sz     = size_of(t);
    is_mem = v & (st | ld);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = is_mem && (int'(addr % 4) % sz != 0);
`else
    mis = 1'b0;
`endif
    active     = is_mem && !mis;
    tout       = active && delay >= MAXW;
    exp_stalls = !active ? 0 : (tout ? 1 + MAXW : delay + 2);
    exp_reqs   = !active ? 0 : (tout ? MAXW : delay + 1);
    stalls = 0; reqs = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      if (!stall_out) begin
        done = 1'b1;
        dm_ready = 1'b0;
        check({tag, "_req_idle"}, {31'd0, dm_req}, 32'd0);
      end else begin
        if (stalls > 0) begin
          check({tag, "_bubble_valid"}, {31'd0, wb_valid}, 32'd0);
          check({tag, "_bubble_we"}, {31'd0, wb_we}, 32'd0);
        end
        stalls++;
        if (dm_req) begin
          if (reqs == 0) begin
            check({tag, "_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
            check({tag, "_be"}, {28'd0, dm_be}, {28'd0, model_be(addr, t, st)});
            check({tag, "_we"}, {31'd0, dm_we}, {31'd0, st});
            if (st) check({tag, "_wdata"}, dm_wdata, model_wdata(d2, t));
          end
          dm_ready = (reqs == delay);
          dm_rdata = (reqs == delay) ? rdata : $urandom;
          reqs++;
        end else begin
          dm_ready = 1'b0;
        end
      end
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_reqs"}, reqs, exp_reqs);
    @(posedge clk); #1;
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, {31'd0, v});
    check({tag, "_wb_we"}, {31'd0, wb_we}, {31'd0, v & we & ~tout & ~mis});
    check({tag, "_bus_err"}, {31'd0, bus_err_out}, {31'd0, tout});
    check({tag, "_misalign"}, {31'd0, misalign_out}, {31'd0, mis});
    case (ctrl)
      2'b00:   exp_data = addr;
      2'b01:   exp_data = model_load(addr, t, rdata);
      2'b10:   exp_data = sum_out_in;
      default: exp_data = imm_in;
    endcase
    data_known = (ctrl != 2'b01) || (active && !tout);
    if (v) begin
      check({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
      if (data_known) check({tag, "_wb_data"}, wb_data, exp_data);
    end
    $display("txn %s valid=%0d mem=%0d addr=%h type=%b stalls=%0d reqs=%0d wb_data=%h err=%0d mis=%0d",
             tag, v, is_mem, addr, t, stalls, reqs, wb_data, bus_err_out, misalign_out);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; result_in = '0; data2_in = '0; sum_out_in = '0; imm_in = '0;
    rd_in = '0; we_in = 1'b0; controlRF_in = '0; Type_dm_in = '0; store_in = 1'b0;
    load_in = 1'b0; dm_ready = 1'b0; dm_rdata = '0;
    #1;
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    check("rst_req", {31'd0, dm_req}, 32'd0);
    check("rst_dm_we", {31'd0, dm_we}, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_be", {28'd0, dm_be}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_flags", {30'd0, bus_err_out, misalign_out}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_op("add",  1, 32'h1234, 32'h0, 3'b010, 0, 0, 1, 2'b00, 5'd3, 0, 32'h0);
    do_op("sb",   1, 32'h103, 32'hAB, 3'b000, 1, 0, 0, 2'b00, 5'd0, 0, 32'h0);
    do_op("lb",   1, 32'h102, 32'h0, 3'b000, 0, 1, 1, 2'b01, 5'd5, 0, 32'h0080_0000);
    do_op("lbu",  1, 32'h102, 32'h0, 3'b100, 0, 1, 1, 2'b01, 5'd6, 0, 32'h0080_0000);
    do_op("lh",   1, 32'h2, 32'h0, 3'b001, 0, 1, 1, 2'b01, 5'd7, 3, 32'h8001_1234);
    do_op("tmo",  1, 32'h40, 32'h0, 3'b010, 0, 1, 1, 2'b10, 5'd8, 1000, 32'h0);
    do_op("after_tmo", 1, 32'h55, 32'h0, 3'b010, 0, 0, 1, 2'b11, 5'd9, 0, 32'h0);
    do_op("sh",   1, 32'h10E, 32'hBEEF, 3'b001, 1, 1, 0, 2'b00, 5'd0, 1, 32'h0);
    do_op("bubble", 0, 32'h77, 32'h0, 3'b010, 0, 1, 1, 2'b00, 5'd1, 0, 32'h0);

    // Reset pulsed while the bus request is outstanding.
    ex_valid = 1'b1; result_in = 32'h200; Type_dm_in = 3'b010; load_in = 1'b1; store_in = 1'b0;
    we_in = 1'b1; controlRF_in = 2'b01; dm_ready = 1'b0;
    for (int c = 0; c < 5 && !dm_req; c++) @(negedge clk);
    check("rst_mid_req_seen", {31'd0, dm_req}, 32'd1);
    #1; rst = 1'b1; ex_valid = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, dm_req}, 32'd0);
    check("rst_mid_stall", {31'd0, stall_out}, 32'd0);
    check("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    #1; rst = 1'b0;
    @(posedge clk); #1;

    do_op("lw_0x6", 1, 32'h6, 32'h0, 3'b010, 0, 1, 1, 2'b01, 5'd10, 0, 32'hCAFE_F00D);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] kind;
      kind = 3'($urandom_range(0, 4));
      do_op("rnd", ($urandom % 8) != 0, $urandom, $urandom, 3'($urandom),
            kind == 3'd2 || kind == 3'd4, kind == 3'd1 || kind == 3'd4, 1'($urandom),
            2'($urandom), 5'($urandom), $urandom_range(0, 5), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage that consumes the EX/MEM pipeline register outputs, runs loads and stores against data memory over a valid/ready bus, and drives the registered MEM/WB writeback slot. Non-memory instructions pass through with one cycle of latency. Memory instructions run a 3-state FSM and hold the upstream pipeline with `stall_out` until the bus transfer completes. Loads are lane-extracted and sign- or zero-extended; stores get byte enables and lane replication.

## Interface
Parameters:
- `MAX_WAIT`, default 255: REQ cycles without `dm_ready` before the access is aborted. Legal range 1–255.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `ex_valid` in 1: the EX/MEM slot holds a real instruction; 0 means bubble.
- `result_in` in 32: ALU result, also the effective address.
- `data2_in` in 32: store data (rs2).
- `sum_out_in` in 32: PC+4.
- `imm_in` in 32: immediate.
- `rd_in` in 5: destination register.
- `we_in` in 1: register-file write enable.
- `controlRF_in` in 2: writeback source select.
- `Type_dm_in` in 3: access size and sign (RISC-V funct3).
- `store_in` in 1: store instruction.
- `load_in` in 1: load instruction.
- `stall_out` out 1: freezes EX/MEM and all earlier stages.
- `dm_req` out 1: bus request.
- `dm_we` out 1: bus write.
- `dm_addr` out 32: word-aligned bus address, bits [1:0] = 0.
- `dm_wdata` out 32: bus write data.
- `dm_be` out 4: byte enables.
- `dm_ready` in 1: bus accepts or completes the transfer.
- `dm_rdata` in 32: read data, valid when `dm_ready` = 1.
- `wb_valid` out 1: MEM/WB slot holds a real instruction.
- `wb_rd` out 5: writeback destination register.
- `wb_we` out 1: writeback enable.
- `wb_data` out 32: writeback value.
- `bus_err_out` out 1: timeout abort flag, travels with the WB slot.
- `misalign_out` out 1: misalignment flag, travels with the WB slot.

## Operation
- Memory op: `ex_valid & (load_in | store_in)`. If both are set, the instruction is a store.
- `Type_dm_in` encoding:
  - 000 byte signed, 001 half signed, 010 word.
  - 100 byte unsigned, 101 half unsigned.
  - 011, 110 and 111 are treated as word.
- FSM state IDLE:
  - On a memory op: `stall_out` = 1 combinationally, next state REQ.
  - Otherwise: the WB slot loads from the inputs at the edge.
- FSM state REQ:
  - Outputs: `dm_req` = 1, `stall_out` = 1; address, data, be and we are held stable.
  - Handshake occurs at the edge where `dm_req & dm_ready`. Read data is captured into an internal buffer, next state RESP.
  - Wait counter reaches `MAX_WAIT`: `dm_req` drops, next state RESP with an internal error flag set.
- FSM state RESP:
  - `stall_out` = 0.
  - At the edge, the WB slot loads this instruction and the state returns to IDLE.
  - The upstream stages advance at that same edge, so the instruction is never reissued.
- While `stall_out` = 1, each edge writes a bubble into the WB slot: `wb_valid` = 0 and `wb_we` = 0.
- `wb_data` source by `controlRF_in`:
  - 00: `result_in`.
  - 01: extracted load data.
  - 10: `sum_out_in`.
  - 11: `imm_in`.
- Store lane handling:
  - SB: `dm_be` = 1<<addr[1:0]; `dm_wdata` = byte replicated ×4.
  - SH: `dm_be` = addr[1] ? 1100 : 0011; `dm_wdata` = half replicated ×2.
  - SW: `dm_be` = 1111.
  - Loads: `dm_be` = 1111, `dm_we` = 0.
- Load extraction: `dm_rdata` >> (8·addr[1:0]), then sign- or zero-extend per `Type_dm_in`.
- Timeout abort: WB slot loads with `wb_we` forced to 0 and `bus_err_out` = 1 for that slot.

## Timing
- Non-memory instruction: WB slot updates at the first edge; latency 1.
- Memory op with `dm_ready` high in the first REQ cycle:
  - Cycle 0 IDLE (stall), cycle 1 REQ with handshake, cycle 2 RESP.
  - WB slot updates at the end of cycle 2; latency 3, with 2 stall cycles.
- Each extra cycle of `dm_ready` low adds one cycle of stall.
- `dm_req` is a registered output and drops in the cycle after the handshake.
- Reset value of every output is 0, applied immediately and asynchronously:
  - state IDLE, wait counter 0;
  - `dm_req` = 0, `stall_out` = 0, all `wb_*` = 0, both flags = 0.
  - Reset during REQ abandons the transfer.
- `wb_rd` and `wb_data` for a bubble are don't-care; the bench checks them only when `wb_valid` = 1.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access (half with addr[0] = 1, or word with addr[1:0] ≠ 0) issues no bus request and does not stall.
  - The WB slot loads at the next edge with `wb_we` = 0 and `misalign_out` = 1.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Low address bits are ignored for the access size (half clears bit 0, word clears bits [1:0]).
  - `misalign_out` is tied to 0.

## Test plan
- ADD: `controlRF_in` = 00, `result_in` = 0x1234 → next edge `wb_valid` = 1, `wb_data` = 0x1234, `stall_out` never asserted.
- SB: addr 0x103, data2 0xAB, `dm_ready` high in first REQ → `dm_be` = 1000, `dm_wdata` = 0xABABABAB, `dm_addr` = 0x100, stall for exactly 2 cycles.
- LB: addr 0x102, `dm_rdata` 0x00800000 → `wb_data` = 0xFFFFFF80; LBU at the same address → 0x00000080.
- LH: addr 0x2, `dm_ready` delayed 3 cycles → stall for 5 cycles, bubbles in WB during stall, `wb_data` = sign-extended `dm_rdata`[31:16].
- `dm_ready` never asserted, `MAX_WAIT` = 4 → abort after 4 REQ cycles, `bus_err_out` = 1, `wb_we` = 0, pipeline resumes.
- `rst` pulsed mid-REQ → `dm_req` and `stall_out` go to 0 immediately; an LW at 0x6 with the macro defined gives `misalign_out` = 1 and no `dm_req`.
